// File: rtl/single_clk_ram_64b.sv
// single_clk_ram_64b
//   Single-clock simple dual-port RAM (one write port, one read port) holding
//   the d_plus / d_minus digit-history vectors of the divider digit generator.
//   Built as a register array so a reset clears every word in one cycle.
//
// Ports
//   data        in   DATA_WIDTH  write data (full word, no byte enables)
//   wr_addr     in   ADDR_WIDTH  write address
//   rd_addr     in   ADDR_WIDTH  read address
//   we          in   1           write enable, active-high
//   asyn_reset  in   1           synchronous active-high reset (historical name)
//   clk         in   1           clock, rising edge
//   q           out  DATA_WIDTH  registered read data, one cycle latency
module single_clk_ram_64b #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 7
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic                  we,
    input  logic                  asyn_reset,
    input  logic                  clk,
    output logic [DATA_WIDTH-1:0] q
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    // Zero power-up values keep simulation deterministic before the first reset.
    logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};
    logic [DATA_WIDTH-1:0] q_r = '0;

    // Reset wins over a same-cycle write; the read samples the pre-edge array,
    // so a same-address collision returns the old word (read-first).
    always_ff @(posedge clk) begin
        if (asyn_reset) begin
            q_r <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            q_r <= mem[rd_addr];
            if (we) begin
                mem[wr_addr] <= data;
            end
        end
    end

    assign q = q_r;

endmodule

// File: tb/tb_single_clk_ram_64b.sv
// Directed bench for single_clk_ram_64b: reset clearing, read latency,
// read-first collisions, write-enable gating, reset priority and a full sweep.
module tb_single_clk_ram_64b;

    logic        clk = 1'b0;
    logic        asyn_reset = 1'b0;
    logic [63:0] data = '0;
    logic [6:0]  wr_addr = '0;
    logic [6:0]  rd_addr = '0;
    logic        we = 1'b0;
    logic [63:0] q;

    int n_checks = 0;
    int n_fail   = 0;

    single_clk_ram_64b dut (
        .data       (data),
        .wr_addr    (wr_addr),
        .rd_addr    (rd_addr),
        .we         (we),
        .asyn_reset (asyn_reset),
        .clk        (clk),
        .q          (q)
    );

    always #5 clk = ~clk;

    // Advance one rising edge, then settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [63:0] exp_v;
        #1;
        check("powerup_q", q, 64'h0);

        // 1. Reset clears contents and q.
        we = 1'b1; wr_addr = 7'd5; data = 64'hDEAD_BEEF_0123_4567;
        tick();
        we = 1'b0; rd_addr = 7'd5;
        tick();
        check("pre_reset_read5", q, 64'hDEAD_BEEF_0123_4567);
        asyn_reset = 1'b1;
        tick();
        check("q_after_reset", q, 64'h0);
        asyn_reset = 1'b0;
        tick();
        check("read5_after_reset", q, 64'h0);

        // 2. Basic write/read with one-cycle latency.
        we = 1'b1; wr_addr = 7'd0; data = 64'h8000_0000_0000_0001;
        tick();
        wr_addr = 7'd127; data = '1;
        tick();
        we = 1'b0; rd_addr = 7'd0;
        tick();
        check("read_addr0", q, 64'h8000_0000_0000_0001);
        rd_addr = 7'd127;
        #2;
        check("q_holds_before_edge", q, 64'h8000_0000_0000_0001);
        tick();
        check("read_addr127", q, 64'hFFFF_FFFF_FFFF_FFFF);

        // 3. Read-first on same-address collision.
        we = 1'b1; wr_addr = 7'd3; data = 64'h1;
        tick();
        data = 64'h2; rd_addr = 7'd3;
        tick();
        check("collision_old_word", q, 64'h1);
        we = 1'b0;
        tick();
        check("collision_new_word", q, 64'h2);

        // 4. we=0 leaves memory untouched.
        we = 1'b1; wr_addr = 7'd10; data = 64'h1234_5678_9ABC_DEF0;
        tick();
        we = 1'b0; data = '1;
        tick();
        rd_addr = 7'd10;
        tick();
        check("we_gating_addr10", q, 64'h1234_5678_9ABC_DEF0);

        // Independent ports: write addr 20 while reading addr 10.
        we = 1'b1; wr_addr = 7'd20; data = 64'h0F0F_0F0F_0F0F_0F0F; rd_addr = 7'd10;
        tick();
        check("indep_read10", q, 64'h1234_5678_9ABC_DEF0);
        we = 1'b0; rd_addr = 7'd20;
        tick();
        check("indep_read20", q, 64'h0F0F_0F0F_0F0F_0F0F);

        // 5. Reset has priority over a same-cycle write.
        we = 1'b1; wr_addr = 7'd7; data = 64'h5555_5555_5555_5555;
        tick();
        data = 64'hAAAA_AAAA_AAAA_AAAA; asyn_reset = 1'b1;
        tick();
        asyn_reset = 1'b0; we = 1'b0; rd_addr = 7'd7;
        tick();
        check("reset_priority_addr7", q, 64'h0);
        rd_addr = 7'd10;
        tick();
        check("reset_cleared_addr10", q, 64'h0);

        // 6. Full sweep: addr i holds i << (i % 64).
        we = 1'b1;
        for (int i = 0; i < 128; i++) begin
            wr_addr = 7'(i);
            data = 64'(i) << (i % 64);
            tick();
        end
        we = 1'b0;
        for (int i = 0; i < 128; i++) begin
            rd_addr = 7'(i);
            tick();
            exp_v = 64'(i) << (i % 64);
            check($sformatf("sweep_addr%0d", i), q, exp_v);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
